// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst arbiter (clk, rst, req[4], burst_len, stall) -> registered one-hot sel, gnt_id, busy, xfer for a 4-input one-hot mux
module mux_rr_arbiter #(
  parameter int BURST_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             req,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   stall,
  output logic [3:0]             sel,
  output logic [1:0]             gnt_id,
  output logic                   busy,
  output logic                   xfer
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t                 state, state_n;
  logic [3:0]             sel_n;
  logic [1:0]             gnt_n, ptr, ptr_n, win;
  logic [BURST_WIDTH-1:0] cnt, cnt_n, beats, beats_n;
  assign busy = state == GRANT;
  assign xfer = busy & req[gnt_id] & ~stall;
  always_comb begin
    win = ptr;
    for (int k = 4; k >= 1; k--) win = req[ptr + 2'(k)] ? ptr + 2'(k) : win;
  end
  always_comb begin
    state_n = state;
    sel_n   = sel;
    gnt_n   = gnt_id;
    cnt_n   = cnt;
    beats_n = beats;
    ptr_n   = ptr;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        sel_n   = 4'b0001 << win;
        gnt_n   = win;
        beats_n = (burst_len == '0) ? BURST_WIDTH'(1) : burst_len;
        cnt_n   = '0;
        ptr_n   = win;
      end
    end else if (!req[gnt_id] || (xfer && cnt == beats - 1'b1)) begin
      state_n = IDLE;
      sel_n   = '0;
      gnt_n   = '0;
      cnt_n   = '0;
    end else if (xfer) begin
      cnt_n = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      gnt_id <= '0;
      cnt    <= '0;
      beats  <= BURST_WIDTH'(1);
      ptr    <= 2'd3;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      gnt_id <= gnt_n;
      cnt    <= cnt_n;
      beats  <= beats_n;
      ptr    <= ptr_n;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: table-driven cycle vectors plus a hand-written burst sequence for mux_rr_arbiter
module tb_mux_rr_arbiter;
  logic       clk = 0;
  logic       rst, stall, busy, xfer;
  logic [3:0] req, burst_len, sel;
  logic [1:0] gnt_id;
  int         errors = 0, checks = 0;
  mux_rr_arbiter #(.BURST_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .burst_len(burst_len), .stall(stall),
    .sel(sel), .gnt_id(gnt_id), .busy(busy), .xfer(xfer)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] bl;
    logic       stall;
    logic [3:0] sel;
    logic [1:0] gnt;
    logic       busy;
    logic       xfer;
  } vec_t;
  vec_t tv[34];
  function automatic vec_t v(logic r, logic [3:0] q, logic [3:0] b, logic s,
                             logic [3:0] es, logic [1:0] eg, logic eb, logic ex);
    vec_t t;
    t.rst = r; t.req = q; t.bl = b; t.stall = s;
    t.sel = es; t.gnt = eg; t.busy = eb; t.xfer = ex;
    return t;
  endfunction
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  initial begin
    int n, b, x;
    tv[0]  = v(1, 4'hf, 1, 0, 4'h0, 0, 0, 0);
    tv[1]  = v(0, 4'hf, 1, 0, 4'h0, 0, 0, 0);
    tv[2]  = v(0, 4'hf, 1, 0, 4'h1, 0, 1, 1);
    tv[3]  = v(0, 4'hf, 1, 0, 4'h0, 0, 0, 0);
    tv[4]  = v(0, 4'hf, 1, 0, 4'h2, 1, 1, 1);
    tv[5]  = v(0, 4'hf, 1, 0, 4'h0, 0, 0, 0);
    tv[6]  = v(0, 4'hf, 1, 0, 4'h4, 2, 1, 1);
    tv[7]  = v(0, 4'hf, 1, 0, 4'h0, 0, 0, 0);
    tv[8]  = v(0, 4'hf, 1, 0, 4'h8, 3, 1, 1);
    tv[9]  = v(0, 4'hf, 1, 0, 4'h0, 0, 0, 0);
    tv[10] = v(0, 4'hf, 1, 0, 4'h1, 0, 1, 1);
    tv[11] = v(0, 4'h4, 3, 0, 4'h0, 0, 0, 0);
    tv[12] = v(0, 4'h4, 3, 0, 4'h4, 2, 1, 1);
    tv[13] = v(0, 4'h4, 1, 0, 4'h4, 2, 1, 1);
    tv[14] = v(0, 4'h4, 7, 0, 4'h4, 2, 1, 1);
    tv[15] = v(0, 4'h4, 3, 0, 4'h0, 0, 0, 0);
    tv[16] = v(0, 4'h0, 3, 0, 4'h4, 2, 1, 0);
    tv[17] = v(0, 4'h1, 2, 0, 4'h0, 0, 0, 0);
    tv[18] = v(0, 4'h1, 2, 0, 4'h1, 0, 1, 1);
    tv[19] = v(0, 4'h1, 2, 1, 4'h1, 0, 1, 0);
    tv[20] = v(0, 4'h1, 2, 1, 4'h1, 0, 1, 0);
    tv[21] = v(0, 4'h1, 2, 1, 4'h1, 0, 1, 0);
    tv[22] = v(0, 4'h1, 2, 0, 4'h1, 0, 1, 1);
    tv[23] = v(0, 4'h2, 8, 0, 4'h0, 0, 0, 0);
    tv[24] = v(0, 4'h2, 8, 0, 4'h2, 1, 1, 1);
    tv[25] = v(0, 4'h2, 8, 0, 4'h2, 1, 1, 1);
    tv[26] = v(0, 4'h0, 8, 0, 4'h2, 1, 1, 0);
    tv[27] = v(0, 4'h3, 5, 0, 4'h0, 0, 0, 0);
    tv[28] = v(0, 4'h3, 5, 0, 4'h1, 0, 1, 1);
    tv[29] = v(1, 4'h3, 5, 0, 4'h1, 0, 1, 1);
    tv[30] = v(0, 4'h8, 0, 0, 4'h0, 0, 0, 0);
    tv[31] = v(0, 4'h8, 0, 0, 4'h8, 3, 1, 1);
    tv[32] = v(0, 4'h8, 0, 0, 4'h0, 0, 0, 0);
    tv[33] = v(0, 4'h0, 0, 0, 4'h8, 3, 1, 0);
    rst = 1; req = 4'hf; burst_len = 1; stall = 0;
    @(posedge clk);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      rst = tv[i].rst; req = tv[i].req; burst_len = tv[i].bl; stall = tv[i].stall;
      #1;
      chk("sel", i, 32'(sel), 32'(tv[i].sel));
      chk("gnt_id", i, 32'(gnt_id), 32'(tv[i].gnt));
      chk("busy", i, 32'(busy), 32'(tv[i].busy));
      chk("xfer", i, 32'(xfer), 32'(tv[i].xfer));
      chk("onehot0", i, 32'($onehot0(sel)), 32'd1);
    end
    @(negedge clk);
    rst = 0; req = 4'h2; burst_len = 2; stall = 0;
    n = 0;
    while (!busy && n < 5) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_wait", 100, 32'(busy), 32'd1);
    chk("grant_sel", 100, 32'(sel), 32'h2);
    b = 0; x = 0;
    while (busy && b < 20) begin
      b++;
      if (xfer) x++;
      @(negedge clk);
      #1;
    end
    chk("burst_cycles", 101, b, 2);
    chk("burst_xfers", 101, x, 2);
    chk("idle_after", 101, 32'(sel), 32'h0);
    req = 4'h0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
